// File: rtl/lc3_mem_arbiter.sv
// lc3_mem_arbiter: shares one single-port memory between the LC3 fetch
// path and the MemAccess data path. Data wins arbitration by default; a
// saturating starve counter lets a waiting fetch through after
// STARVE_LIMIT consecutive losses. Each access takes at least 3 cycles:
// IDLE (grant) -> BUSY_x (mem_req until mem_ack) -> DONE_x (completion pulse).
module lc3_mem_arbiter #(
  parameter int unsigned AW           = 16,
  parameter int unsigned DW           = 16,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          I_macc,
  input  logic [AW-1:0] pc,
  output logic [DW-1:0] Instr_dout,
  output logic          complete_instr,
  input  logic          D_macc,
  input  logic [AW-1:0] Data_addr,
  input  logic          Data_rd,
  input  logic [DW-1:0] Data_din,
  output logic [DW-1:0] Data_dout,
  output logic          complete_data,
  output logic          mem_req,
  output logic [AW-1:0] mem_addr,
  output logic          mem_rd,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  input  logic          mem_ack,
  output logic          grant_d
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    BUSY_I = 3'd1,
    BUSY_D = 3'd2,
    DONE_I = 3'd3,
    DONE_D = 3'd4
  } state_t;

  localparam logic [3:0] STARVE_LIM = 4'(STARVE_LIMIT);

  state_t     state;
  state_t     state_nx;
  logic [3:0] starve_cnt;
  logic       win_i;
  logic       win_d;

  // Arbitration decision; only meaningful in IDLE, data wins unless fetch is starved
  always_comb begin
    win_i = 1'b0;
    win_d = 1'b0;
    if (state == IDLE) begin
      if (I_macc && D_macc) begin
        if (starve_cnt >= STARVE_LIM) win_i = 1'b1;
        else                          win_d = 1'b1;
      end else if (D_macc) begin
        win_d = 1'b1;
      end else if (I_macc) begin
        win_i = 1'b1;
      end
    end
  end

  // State register
  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  // Next-state logic; mem_ack is only honoured while a transaction is in BUSY
  always_comb begin
    state_nx = state;
    case (state)
      IDLE: begin
        if (win_d)      state_nx = BUSY_D;
        else if (win_i) state_nx = BUSY_I;
      end
      BUSY_I:  if (mem_ack) state_nx = DONE_I;
      BUSY_D:  if (mem_ack) state_nx = DONE_D;
      DONE_I:  state_nx = IDLE;
      DONE_D:  state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // State-decoded outputs
  always_comb begin
    mem_req        = (state == BUSY_I) || (state == BUSY_D);
    complete_instr = (state == DONE_I);
    complete_data  = (state == DONE_D);
    grant_d        = (state == BUSY_D) || (state == DONE_D);
  end

  // Starve counter: counts fetch losses to data, saturating, cleared on fetch grant
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      starve_cnt <= '0;
    end else if (win_i) begin
      starve_cnt <= '0;
    end else if (win_d && I_macc && (starve_cnt != 4'hF)) begin
      starve_cnt <= starve_cnt + 4'd1;
    end
  end

  // Request latching at grant and read-data capture at the ack edge
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      mem_addr   <= '0;
      mem_rd     <= 1'b0;
      mem_wdata  <= '0;
      Instr_dout <= '0;
      Data_dout  <= '0;
    end else begin
      if (win_d) begin
        mem_addr  <= Data_addr;
        mem_rd    <= Data_rd;
        mem_wdata <= Data_din;
      end else if (win_i) begin
        mem_addr <= pc;
        mem_rd   <= 1'b1;
      end
      if ((state == BUSY_I) && mem_ack) Instr_dout <= mem_rdata;
      if ((state == BUSY_D) && mem_ack && mem_rd) Data_dout <= mem_rdata;
    end
  end

endmodule

// File: doc/lc3_mem_arbiter.md
Name: lc3_mem_arbiter

Overview:
- Shares one single-port unified memory between the LC3 fetch path (I_macc/pc) and the MemAccess data path (D_macc/Data_addr).
- Sits between the LC3 core and the memory model.
- Returns per-port completion pulses that the pipeline controller uses as complete_instr/complete_data.
- Data accesses have priority; a starvation counter guarantees fetch progress.

Parameters:
AW, 16, address width
DW, 16, data width
STARVE_LIMIT, 4, consecutive lost arbitrations after which a pending fetch wins over data (1..15)

Ports:
clock  in  1  system clock, rising edge
reset  in  1  asynchronous, active-high reset
I_macc  in  1  fetch request; held until complete_instr
pc  in  AW  fetch address
Instr_dout  out  DW  fetched word; valid from complete_instr, held until next fetch completion
complete_instr  out  1  one-cycle fetch completion pulse
D_macc  in  1  data request; held until complete_data
Data_addr  in  AW  data address
Data_rd  in  1  1 = read, 0 = write
Data_din  in  DW  write data
Data_dout  out  DW  read data; valid from complete_data, held until next data read completion
complete_data  out  1  one-cycle data completion pulse (reads and writes)
mem_req  out  1  memory request, held until mem_ack
mem_addr  out  AW  latched address
mem_rd  out  1  latched direction
mem_wdata  out  DW  latched write data
mem_rdata  in  DW  memory read data; valid in the mem_ack cycle
mem_ack  in  1  memory completion, one cycle, may arrive in the first mem_req cycle
grant_d  out  1  1 while a data transaction owns memory (status)

Behaviour:
- Clock and reset: one clock domain.
- Reset is asynchronous and active-high. On reset:
  - state = IDLE, starve count = 0
  - all outputs 0, including Instr_dout and Data_dout
  - an in-flight transaction is aborted with no completion pulse
- States:
  - IDLE
  - BUSY_I
  - BUSY_D
  - DONE_I
  - DONE_D
- IDLE, decision at each rising edge:
  - D_macc only -> BUSY_D.
  - I_macc only -> BUSY_I.
  - Both pending -> BUSY_I if starve count >= STARVE_LIMIT, else BUSY_D.
  - Neither -> stay IDLE.
- Grant edge:
  - Latch address into mem_addr: pc for fetch, Data_addr for data.
  - mem_rd = 1 for fetch, Data_rd for data.
  - mem_wdata = Data_din for data, unchanged for fetch.
  - mem_req = 1 from the next cycle onward.
  - Latched values stay stable for the whole transaction; later changes on pc/Data_addr/Data_din are ignored.
- BUSY_x:
  - Hold mem_req = 1 until a cycle where mem_ack = 1.
  - At that edge: mem_req -> 0; for reads, capture mem_rdata into Instr_dout (BUSY_I) or Data_dout (BUSY_D); go to DONE_x.
  - On a data write, Data_dout is unchanged.
- DONE_x:
  - complete_x = 1 for exactly one cycle, then IDLE.
  - No arbitration occurs in DONE_x.
  - A request still high in the following IDLE cycle is treated as a new request.
- Latency: request sampled at edge t -> mem_req high cycles t+1 .. ack cycle k -> complete at cycle k+1.
  - Minimum request-to-complete is 2 cycles; back-to-back throughput is 1 access per 3 cycles.
- Starve counter:
  - Increments, saturating at 15, on each IDLE decision where I_macc = 1 and data is granted.
  - Clears to 0 when fetch is granted.
  - Unchanged otherwise.
- Requests:
  - A request dropped mid-transaction does not abort it; the completion pulse still fires.
  - mem_ack while mem_req = 0 is ignored.
- grant_d = 1 in BUSY_D and DONE_D, else 0.
- complete_instr and complete_data are never high in the same cycle.

Test Plan:
1. Reset release, fetch pc=0x3000, mem_ack in the first req cycle with rdata=0x1234 -> mem_req high 1 cycle, mem_addr=0x3000, mem_rd=1; complete_instr pulses 2 cycles after the request; Instr_dout=0x1234.
2. Data write Data_addr=0x4000, Data_din=0xBEEF, Data_rd=0, ack after 3 wait cycles -> mem_req high 4 cycles, mem_wdata=0xBEEF, mem_rd=0; one complete_data pulse; Data_dout unchanged.
3. I_macc and D_macc held high together continuously, STARVE_LIMIT=4, immediate acks -> grant order D,D,D,D,I,D,D,D,D,I; no cycle with both completes high.
4. Read at 0x5000 granted, then Data_addr changed to 0x6000 while waiting for ack -> mem_addr stays 0x5000; Data_dout = rdata captured at the ack.
5. Reset asserted mid-BUSY_D -> all outputs 0 asynchronously; no complete_data pulse; next request after release serviced normally.
6. Spurious mem_ack in IDLE, then D_macc dropped mid-transaction -> the spurious ack causes no state change; the transaction completes and complete_data still pulses once.
